dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port `data_memory`. It shares one memory port between the CPU load/store path and a DMA/debug requester using round-robin grants. It sequences reads through the memory's one-cycle registered read latency. Optionally, it clears memory word-by-word after reset so the memory needs no reset loop.

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 33 +++
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter slice.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;

  // Bit positions of each requester in the arbiter's req/gnt vectors
  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; a tie goes to whoever did not win last.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // Reset points at requester 1 so requester 0 wins the first tie
  logic r_last_one;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_last_one ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_one <= 1'b1;
    end else if (|o_gnt) begin
      r_last_one <= o_gnt[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data_memory port between CPU and DMA requesters.
// Define DMEM_ARB_CLEAR_EN to zero the memory word-by-word after reset.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_ARB_CLEAR_EN
  localparam state_t ST_RESET = ST_CLEAR;
`else
  localparam state_t ST_RESET = ST_RUN;
`endif

  state_t            r_state;
  state_t            w_state_next;
  owner_t            r_owner;
  owner_t            w_owner_next;
  logic              r_oor;
  logic              w_oor_next;
  logic [1:0]        w_gnt;
  logic              w_run;
  logic              w_clearing;
  logic              w_clr_last;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_sel_we;
  logic              w_sel_in_range;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Reset is folded in so nothing reaches memory or requesters while held
  assign w_run      = (r_state == ST_RUN) && rst;
  assign w_clearing = (r_state == ST_CLEAR) && rst;

`ifdef DMEM_ARB_CLEAR_EN
  logic [CNT_W-1:0] r_clr_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clr_cnt <= '0;
    end else if (w_clearing) begin
      r_clr_cnt <= r_clr_cnt + CNT_W'(1);
    end
  end

  assign w_clr_addr = ADDR_W'(r_clr_cnt);
  assign w_clr_last = (r_clr_cnt == CNT_W'(DEPTH - 1));
`else
  assign w_clr_addr = '0;
  assign w_clr_last = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RESET;
      r_owner <= OWN_NONE;
      r_oor   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_oor   <= w_oor_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_CLEAR: if (w_clr_last) w_state_next = ST_RUN;
      ST_RUN:   w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_run),
    .i_req ({dma_req, cpu_req}),
    .o_gnt (w_gnt)
  );

  // Out-of-range accesses are granted but never reach the memory pins
  always_comb begin
    w_sel_we         = 1'b0;
    w_sel_addr       = '0;
    w_sel_wdata      = '0;
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_data_in      = '0;
    w_owner_next     = OWN_NONE;
    w_oor_next       = 1'b0;
    if (w_gnt[REQ_CPU]) begin
      w_sel_we    = cpu_we;
      w_sel_addr  = cpu_addr;
      w_sel_wdata = cpu_wdata;
    end else if (w_gnt[REQ_DMA]) begin
      w_sel_we    = dma_we;
      w_sel_addr  = dma_addr;
      w_sel_wdata = dma_wdata;
    end
    w_sel_in_range = (w_sel_addr < ADDR_W'(DEPTH));
    if (w_clearing) begin
      mem_address      = w_clr_addr;
      mem_write_enable = 1'b1;
    end else if (|w_gnt) begin
      if (w_sel_in_range) begin
        mem_address      = w_sel_addr;
        mem_write_enable = w_sel_we;
        mem_data_in      = w_sel_wdata;
      end
      if (!w_sel_we) begin
        w_owner_next = w_gnt[REQ_CPU] ? OWN_CPU : OWN_DMA;
        w_oor_next   = !w_sel_in_range;
      end
    end
  end

  assign init_done  = (r_state == ST_RUN);
  assign cpu_gnt    = w_gnt[REQ_CPU];
  assign dma_gnt    = w_gnt[REQ_DMA];
  assign cpu_rvalid = (r_owner == OWN_CPU);
  assign dma_rvalid = (r_owner == OWN_DMA);
  assign cpu_rdata  = (cpu_rvalid && !r_oor) ? mem_data_out : '0;
  assign dma_rdata  = (dma_rvalid && !r_oor) ? mem_data_out : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a queue-based reference model predicts grants,
// memory drive and read returns; a separate monitor checks read returns.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int AW     = $clog2(DEPTH);
`ifdef DMEM_ARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic init_done;
  logic cpu_req = 1'b0, cpu_we = 1'b0, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0, cpu_rdata;
  logic dma_req = 1'b0, dma_we = 1'b0, dma_gnt, dma_rvalid;
  logic [ADDR_W-1:0] dma_addr = '0;
  logic [DATA_W-1:0] dma_wdata = '0, dma_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out = '0;

  int assertCount = 0;
  int failCount   = 0;
  int cycleCnt    = 0;

  logic [DATA_W-1:0] modelMem [DEPTH];
  bit   lastWinDma;
  int   initLeft;
  bit   cpuOn, dmaOn;
  txn_t cpuPend[$], dmaPend[$];
  rsp_t cpuExp[$], dmaExp[$];
  rsp_t monE;

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  function automatic logic [DATA_W-1:0] initVal(int i);
    return 32'hC0DE_0000 | 32'(i * 7 + 1);
  endfunction

  // Stand-in for data_memory: synchronous write, registered read
  logic [DATA_W-1:0] tbMem [DEPTH];
  bit memLoaded = 1'b0;
  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < DEPTH; i++) tbMem[i] <= initVal(i);
      memLoaded <= 1'b1;
    end else if (mem_address < DEPTH) begin
      if (mem_write_enable) tbMem[mem_address[AW-1:0]] <= mem_data_in;
      mem_data_out <= tbMem[mem_address[AW-1:0]];
    end else begin
      mem_data_out <= 32'hBAD0_BAD0;
    end
  end

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  task automatic pushTxn(bit toDma, logic we, logic [ADDR_W-1:0] addr, logic [DATA_W-1:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    if (toDma) dmaPend.push_back(t);
    else cpuPend.push_back(t);
  endtask

  // One clock cycle: present requests, then at the falling edge predict and compare
  task automatic applyStimulus(bit dense);
    txn_t t;
    rsp_t e;
    bit gc, gd, inR, inClear;
    if (!cpuOn && cpuPend.size() > 0 && (dense || $urandom_range(0, 2) != 0)) cpuOn = 1'b1;
    if (!dmaOn && dmaPend.size() > 0 && (dense || $urandom_range(0, 2) != 0)) dmaOn = 1'b1;
    if (cpuOn) begin
      cpu_req = 1'b1; cpu_we = cpuPend[0].we; cpu_addr = cpuPend[0].addr; cpu_wdata = cpuPend[0].wdata;
    end else begin
      cpu_req = 1'b0; cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom; cpu_wdata = $urandom;
    end
    if (dmaOn) begin
      dma_req = 1'b1; dma_we = dmaPend[0].we; dma_addr = dmaPend[0].addr; dma_wdata = dmaPend[0].wdata;
    end else begin
      dma_req = 1'b0; dma_we = 1'($urandom_range(0, 1)); dma_addr = $urandom; dma_wdata = $urandom;
    end
    @(negedge clk);
    gc = 1'b0; gd = 1'b0;
    inClear = (initLeft > 0);
    if (inClear) begin
      checkOutput("init_done_clear", 32'(init_done), 32'd0);
      checkOutput("clear_we", 32'(mem_write_enable), 32'd1);
      checkOutput("clear_addr", mem_address, 32'(DEPTH - initLeft));
      checkOutput("clear_data", mem_data_in, 32'd0);
      modelMem[DEPTH - initLeft] = '0;
      initLeft--;
    end else begin
      checkOutput("init_done_run", 32'(init_done), 32'd1);
      if (cpuOn && dmaOn) begin
        gc = lastWinDma; gd = !lastWinDma;
      end else begin
        gc = cpuOn; gd = dmaOn;
      end
      if (gc || gd) lastWinDma = gd;
    end
    checkOutput("cpu_gnt", 32'(cpu_gnt), 32'(gc));
    checkOutput("dma_gnt", 32'(dma_gnt), 32'(gd));
    if (gc || gd) begin
      if (gc) begin t = cpuPend.pop_front(); cpuOn = 1'b0; end
      else    begin t = dmaPend.pop_front(); dmaOn = 1'b0; end
      inR = (t.addr < DEPTH);
      if (inR) begin
        checkOutput("mem_addr", mem_address, t.addr);
        checkOutput("mem_we", 32'(mem_write_enable), 32'(t.we));
        checkOutput("mem_data", mem_data_in, t.wdata);
        if (t.we) modelMem[t.addr[AW-1:0]] = t.wdata;
      end else begin
        checkOutput("oor_we", 32'(mem_write_enable), 32'd0);
        checkOutput("oor_addr_bounded", 32'(mem_address < DEPTH), 32'd1);
      end
      if (!t.we) begin
        e.data = inR ? modelMem[t.addr[AW-1:0]] : '0;
        e.cyc  = cycleCnt + 1;
        if (gc) cpuExp.push_back(e);
        else    dmaExp.push_back(e);
      end
    end else if (!inClear) begin
      checkOutput("idle_we", 32'(mem_write_enable), 32'd0);
      checkOutput("idle_addr", mem_address, 32'd0);
      checkOutput("idle_data", mem_data_in, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  // Hold reset for n cycles, checking outputs stay quiet, then restart the model
  task automatic doReset(int n);
    rst = 1'b0;
    cpuExp.delete();
    dmaExp.delete();
    repeat (n) begin
      @(negedge clk);
      checkOutput("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      checkOutput("rst_dma_gnt", 32'(dma_gnt), 32'd0);
      checkOutput("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      checkOutput("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
      checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
      checkOutput("rst_dma_rdata", dma_rdata, 32'd0);
      checkOutput("rst_mem_we", 32'(mem_write_enable), 32'd0);
      checkOutput("rst_owner", 32'(dut.r_owner), 32'(OWN_NONE));
      checkOutput("rst_init_done", 32'(init_done), CLEAR_EN ? 32'd0 : 32'd1);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    lastWinDma = 1'b1;
    initLeft = CLEAR_EN ? DEPTH : 0;
  endtask

  task automatic runUntilIdle(int budget, bit dense);
    int n = 0;
    while ((cpuPend.size() > 0 || dmaPend.size() > 0 || cpuExp.size() > 0 ||
            dmaExp.size() > 0 || initLeft > 0) && n < budget) begin
      applyStimulus(dense);
      n++;
    end
    if (n >= budget) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL idle_budget: still busy after %0d cycles, required idle", n);
    end
  endtask

  // Read-return monitor: every rvalid must match the oldest expected response
  always @(negedge clk) begin
    if (rst) begin
      if (cpu_rvalid) begin
        if (cpuExp.size() == 0) checkOutput("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
        else begin
          monE = cpuExp.pop_front();
          checkOutput("cpu_rdata", cpu_rdata, monE.data);
          checkOutput("cpu_rvalid_cycle", 32'(cycleCnt), 32'(monE.cyc));
        end
      end else begin
        checkOutput("cpu_rdata_idle", cpu_rdata, 32'd0);
        if (cpuExp.size() > 0 && cpuExp[0].cyc <= cycleCnt) begin
          void'(cpuExp.pop_front());
          checkOutput("cpu_rvalid_missing", 32'(cpu_rvalid), 32'd1);
        end
      end
      if (dma_rvalid) begin
        if (dmaExp.size() == 0) checkOutput("dma_rvalid_unexpected", 32'(dma_rvalid), 32'd0);
        else begin
          monE = dmaExp.pop_front();
          checkOutput("dma_rdata", dma_rdata, monE.data);
          checkOutput("dma_rvalid_cycle", 32'(cycleCnt), 32'(monE.cyc));
        end
      end else begin
        checkOutput("dma_rdata_idle", dma_rdata, 32'd0);
        if (dmaExp.size() > 0 && dmaExp[0].cyc <= cycleCnt) begin
          void'(dmaExp.pop_front());
          checkOutput("dma_rvalid_missing", 32'(dma_rvalid), 32'd1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) modelMem[i] = initVal(i);
    cpuOn = 1'b0;
    dmaOn = 1'b0;
    @(posedge clk);
    #1;
    doReset(3);

    // CPU read held across any clear, then write 0xDEADBEEF to 5 and read it back
    pushTxn(1'b0, 1'b0, 32'd3, 32'h1111_1111);
    pushTxn(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    pushTxn(1'b0, 1'b0, 32'd5, 32'h0);
    runUntilIdle(200, 1'b1);

    // Both sides reading back-to-back must alternate
    for (int i = 0; i < 3; i++) begin
      pushTxn(1'b0, 1'b0, 32'(i + 10), 32'($urandom));
      pushTxn(1'b1, 1'b0, 32'(i + 20), 32'($urandom));
    end
    runUntilIdle(50, 1'b1);

    // DMA out-of-range write is dropped; out-of-range read returns zero
    pushTxn(1'b1, 1'b1, 32'd40, 32'hFEED_F00D);
    pushTxn(1'b1, 1'b0, 32'd40, 32'h0);
    pushTxn(1'b1, 1'b0, 32'd8, 32'h0);
    runUntilIdle(50, 1'b1);

    // Reset in the cycle after a CPU read grant drops the pending return
    pushTxn(1'b0, 1'b0, 32'd7, 32'h0);
    applyStimulus(1'b1);
    doReset(2);
    runUntilIdle(200, 1'b1);

`ifdef DMEM_ARB_CLEAR_EN
    // Reset part-way through the clear restarts it from word 0
    doReset(2);
    pushTxn(1'b0, 1'b0, 32'd1, 32'h0);
    repeat (10) applyStimulus(1'b1);
    doReset(2);
    runUntilIdle(200, 1'b1);
`endif

    // Randomized mixed traffic with gaps, including out-of-range addresses
    repeat (4) begin
      repeat (50) begin
        pushTxn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, DEPTH + 7)), $urandom);
      end
      runUntilIdle(2000, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
